mor1kx_tlb_reload_arbiter: RTL and testbench

Arbitrates the hardware TLB-reload page-table walks of the IMMU and DMMU onto a single word-read memory port. It sits directly downstream of each MMU's `tlb_reload_req/ack/addr/data` interface, and directly upstream of the bus interface unit.

The grant is locked to one MMU for the whole multi-level walk, as long as that MMU holds its request high. Bus errors and timeouts return a zero word, which the MMU's walker treats as a pagefault.

---
 rtl/mor1kx_tlb_reload_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mor1kx_tlb_reload_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_tlb_reload_arbiter.sv
// Shares one word-read bus port between the IMMU and DMMU page-table walkers.
// A grant stays with one MMU for its whole walk. Failed or timed-out reads come back as a zero word.
module mor1kx_tlb_reload_arbiter #(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_TLB_RELOAD_TIMEOUT = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,
    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,
    output logic                            bus_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] bus_adr_o,
    input  logic                            bus_ack_i,
    input  logic                            bus_err_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int W   = OPTION_OPERAND_WIDTH;
    localparam int TMO = OPTION_TLB_RELOAD_TIMEOUT;
    localparam int CW  = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TMO == 0) ? '0 : CW'(TMO - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flush_q, flush_d;
    logic          bus_req_q, bus_req_d;
    logic [W-1:0]  bus_adr_q, bus_adr_d;
    logic          immu_ack_q, immu_ack_d, dmmu_ack_q, dmmu_ack_d;
    logic [W-1:0]  immu_data_q, immu_data_d, dmmu_data_q, dmmu_data_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          idle_gnt, cur_req, tmo_hit, rd_done, rd_err;
    logic [W-1:0]  idle_addr, cur_addr, rd_word;

    // On a tie the MMU not served last wins.
    assign idle_gnt  = (immu_req_i && dmmu_req_i) ? !last_q : dmmu_req_i;
    assign idle_addr = idle_gnt ? dmmu_addr_i : immu_addr_i;
    assign cur_req   = gnt_q ? dmmu_req_i : immu_req_i;
    assign cur_addr  = gnt_q ? dmmu_addr_i : immu_addr_i;

    assign tmo_hit = (TMO != 0) && (cnt_q == CNT_LAST);
    assign rd_done = bus_ack_i || bus_err_i || tmo_hit;
    assign rd_err  = bus_err_i || (!bus_ack_i && tmo_hit);
    assign rd_word = rd_err ? '0 : bus_dat_i;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        flush_d     = flush_q;
        bus_req_d   = bus_req_q;
        bus_adr_d   = bus_adr_q;
        immu_ack_d  = 1'b0;
        dmmu_ack_d  = 1'b0;
        err_d       = 1'b0;
        immu_data_d = immu_data_q;
        dmmu_data_d = dmmu_data_q;
        case (state_q)
            ST_IDLE: begin
                if (immu_req_i || dmmu_req_i) begin
                    gnt_d     = idle_gnt;
                    bus_adr_d = {idle_addr[W-1:2], 2'b00};
                    bus_req_d = 1'b1;
                    cnt_d     = '0;
                    flush_d   = 1'b0;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                // A dropped request aborts the walk, but the bus read must still finish.
                if (!cur_req)
                    flush_d = 1'b1;
                if (cnt_q != CNT_MAX)
                    cnt_d = cnt_q + CW'(1);
                if (rd_done) begin
                    bus_req_d = 1'b0;
                    if (flush_q || !cur_req) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACK;
                        err_d   = rd_err;
                        if (gnt_q) begin
                            dmmu_ack_d  = 1'b1;
                            dmmu_data_d = rd_word;
                        end else begin
                            immu_ack_d  = 1'b1;
                            immu_data_d = rd_word;
                        end
                    end
                end
            end
            ST_ACK: begin
                last_d  = gnt_q;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cur_req) begin
                    bus_adr_d = {cur_addr[W-1:2], 2'b00};
                    bus_req_d = 1'b1;
                    cnt_d     = '0;
                    flush_d   = 1'b0;
                    state_d   = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_adr_q   <= '0;
            immu_ack_q  <= 1'b0;
            dmmu_ack_q  <= 1'b0;
            immu_data_q <= '0;
            dmmu_data_q <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            bus_req_q   <= bus_req_d;
            bus_adr_q   <= bus_adr_d;
            immu_ack_q  <= immu_ack_d;
            dmmu_ack_q  <= dmmu_ack_d;
            immu_data_q <= immu_data_d;
            dmmu_data_q <= dmmu_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign immu_ack_o  = immu_ack_q;
    assign dmmu_ack_o  = dmmu_ack_q;
    assign immu_data_o = immu_data_q;
    assign dmmu_data_o = dmmu_data_q;
    assign bus_req_o   = bus_req_q;
    assign bus_adr_o   = bus_adr_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mor1kx_tlb_reload_arbiter.sv
// Directed bench for the TLB reload arbiter: one instance with a 4-cycle timeout,
// and a second instance with the timeout disabled that shares the same stimulus.
module tb_mor1kx_tlb_reload_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        immu_req, dmmu_req, bus_ack, bus_err;
    logic [31:0] immu_addr, dmmu_addr, bus_dat;

    logic        immu_ack, dmmu_ack, bus_req, busy, err;
    logic [31:0] immu_data, dmmu_data, bus_adr;
    logic        z_immu_ack, z_dmmu_ack, z_bus_req, z_busy, z_err;
    logic [31:0] z_immu_data, z_dmmu_data, z_bus_adr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mor1kx_tlb_reload_arbiter #(.OPTION_OPERAND_WIDTH(32), .OPTION_TLB_RELOAD_TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst),
        .immu_req_i(immu_req), .immu_addr_i(immu_addr), .immu_ack_o(immu_ack), .immu_data_o(immu_data),
        .dmmu_req_i(dmmu_req), .dmmu_addr_i(dmmu_addr), .dmmu_ack_o(dmmu_ack), .dmmu_data_o(dmmu_data),
        .bus_req_o(bus_req), .bus_adr_o(bus_adr), .bus_ack_i(bus_ack), .bus_err_i(bus_err),
        .bus_dat_i(bus_dat), .busy_o(busy), .err_o(err)
    );

    mor1kx_tlb_reload_arbiter #(.OPTION_OPERAND_WIDTH(32), .OPTION_TLB_RELOAD_TIMEOUT(0)) u_dut_nt (
        .clk(clk), .rst(rst),
        .immu_req_i(immu_req), .immu_addr_i(immu_addr), .immu_ack_o(z_immu_ack), .immu_data_o(z_immu_data),
        .dmmu_req_i(dmmu_req), .dmmu_addr_i(dmmu_addr), .dmmu_ack_o(z_dmmu_ack), .dmmu_data_o(z_dmmu_data),
        .bus_req_o(z_bus_req), .bus_adr_o(z_bus_adr), .bus_ack_i(bus_ack), .bus_err_i(bus_err),
        .bus_dat_i(bus_dat), .busy_o(z_busy), .err_o(z_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are checked and inputs changed 1 time unit after each rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        immu_req = 0; dmmu_req = 0; bus_ack = 0; bus_err = 0;
        immu_addr = '0; dmmu_addr = '0; bus_dat = '0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        immu_req = 0; dmmu_req = 0; bus_ack = 0; bus_err = 0;
        immu_addr = '0; dmmu_addr = '0; bus_dat = '0;
        #2;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_immu_data", immu_data, 0);
        chk("rst_dmmu_data", dmmu_data, 0);
        chk("rst_acks", {immu_ack, dmmu_ack, err}, 0);
        do_reset();

        // Single IMMU walk, bus latency 2; low address bits are cleared.
        immu_req = 1; immu_addr = 32'h0000_1006;
        tick();  // c1
        chk("w1_bus_req", bus_req, 1);
        chk("w1_adr", bus_adr, 32'h0000_1004);
        chk("w1_busy", busy, 1);
        tick();  // c2
        chk("w1_wait_req", bus_req, 1);
        bus_ack = 1; bus_dat = 32'h1234_6000;
        tick();  // c3
        bus_ack = 0;
        chk("w1_immu_ack", immu_ack, 1);
        chk("w1_immu_data", immu_data, 32'h1234_6000);
        chk("w1_no_dmmu_ack", dmmu_ack, 0);
        chk("w1_no_err", err, 0);
        chk("w1_req_drop", bus_req, 0);
        immu_addr = 32'h1234_6010;
        tick();  // c4 HOLD
        chk("w1_hold_ack", immu_ack, 0);
        chk("w1_hold_req", bus_req, 0);
        tick();  // c5
        chk("w2_bus_req", bus_req, 1);
        chk("w2_adr", bus_adr, 32'h1234_6010);
        bus_ack = 1; bus_dat = 32'h0ABC_D001;
        tick();  // c6
        bus_ack = 0;
        chk("w2_immu_ack", immu_ack, 1);
        chk("w2_immu_data", immu_data, 32'h0ABC_D001);
        chk("w2_no_dmmu_ack", dmmu_ack, 0);
        immu_req = 0;
        tick();  // c7 HOLD
        chk("w2_hold_busy", busy, 1);
        tick();  // c8 IDLE
        chk("w2_idle_busy", busy, 0);
        chk("w2_idle_req", bus_req, 0);

        // Tie from reset: IMMU first, DMMU waits until IMMU releases.
        do_reset();
        immu_req = 1; immu_addr = 32'h100; dmmu_req = 1; dmmu_addr = 32'h200;
        tick();  // c1
        chk("tie_first_adr", bus_adr, 32'h100);
        bus_ack = 1; bus_dat = 32'hA;
        tick();  // c2
        bus_ack = 0;
        chk("tie_immu_ack", immu_ack, 1);
        chk("tie_dmmu_no_ack", dmmu_ack, 0);
        immu_req = 0;
        tick(2); // c4 IDLE
        chk("tie_idle_req", bus_req, 0);
        tick();  // c5
        chk("tie_dmmu_req", bus_req, 1);
        chk("tie_dmmu_adr", bus_adr, 32'h200);
        bus_ack = 1; bus_dat = 32'hB;
        tick();  // c6
        bus_ack = 0;
        chk("tie_dmmu_ack", dmmu_ack, 1);
        chk("tie_dmmu_data", dmmu_data, 32'hB);
        chk("tie_immu_no_ack", immu_ack, 0);
        dmmu_req = 0;
        tick(2); // c8 IDLE, last = DMMU
        immu_req = 1; dmmu_req = 1;
        tick();  // c9
        chk("tie2_immu_wins", bus_adr, 32'h100);
        bus_ack = 1; bus_dat = 32'hC;
        tick();  // c10
        bus_ack = 0;
        chk("tie2_immu_ack", immu_ack, 1);
        immu_req = 0; dmmu_req = 0;
        tick(2); // c12 IDLE, last = IMMU
        immu_req = 1; dmmu_req = 1;
        tick();  // c13
        chk("tie3_dmmu_wins", bus_adr, 32'h200);

        // Flush: both drop during READ; read completes without an ack.
        immu_req = 0; dmmu_req = 0;
        tick();  // c14
        chk("flush_req_held", bus_req, 1);
        bus_ack = 1; bus_dat = 32'hD;
        tick();  // c15
        bus_ack = 0;
        chk("flush_no_acks", {immu_ack, dmmu_ack, err}, 0);
        chk("flush_idle", busy, 0);
        chk("flush_req_off", bus_req, 0);
        chk("flush_dmmu_data_held", dmmu_data, 32'hB);

        // Timeout 4: bus never answers.
        dmmu_req = 1; dmmu_addr = 32'h0000_0808;
        tick();  // c1
        chk("tmo_req_c1", bus_req, 1);
        chk("tmo_adr", bus_adr, 32'h808);
        tick(3); // c4
        chk("tmo_req_c4", bus_req, 1);
        chk("tmo_no_ack_c4", dmmu_ack, 0);
        tick();  // c5
        chk("tmo_dmmu_ack", dmmu_ack, 1);
        chk("tmo_err", err, 1);
        chk("tmo_data_zero", dmmu_data, 0);
        chk("tmo_req_off", bus_req, 0);
        chk("nt_req_c5", z_bus_req, 1);
        dmmu_req = 1;
        tick(2); // c7: new read after HOLD on the timeout instance
        chk("tmo_relaunch", bus_req, 1);
        chk("tmo_cnt_cleared", dmmu_ack, 0);
        dmmu_req = 0;
        tick(8);
        chk("nt_req_late", z_bus_req, 1);
        chk("nt_no_ack", z_dmmu_ack, 0);

        // Walk lock: DMMU waits while IMMU walk continues.
        do_reset();
        immu_req = 1; immu_addr = 32'h300;
        tick();  // c1
        bus_ack = 1; bus_dat = 32'h1;
        tick();  // c2
        bus_ack = 0;
        immu_addr = 32'h304; dmmu_req = 1; dmmu_addr = 32'h400;
        tick(2); // c4
        chk("lock_immu_adr", bus_adr, 32'h304);
        bus_ack = 1; bus_dat = 32'h2;
        tick();  // c5
        bus_ack = 0;
        chk("lock_immu_ack", immu_ack, 1);
        chk("lock_no_dmmu_ack", dmmu_ack, 0);
        immu_req = 0;
        tick(2); // c7 IDLE
        chk("lock_idle", bus_req, 0);
        tick();  // c8
        chk("lock_dmmu_adr", bus_adr, 32'h400);
        bus_ack = 1; bus_dat = 32'h44;
        tick();  // c9
        bus_ack = 0;
        chk("lock_dmmu_data", dmmu_data, 32'h44);
        dmmu_addr = 32'h404;
        tick(2); // c11
        chk("err_adr", bus_adr, 32'h404);
        bus_ack = 1; bus_err = 1; bus_dat = 32'hFFFF;
        tick();  // c12
        bus_ack = 0; bus_err = 0;
        chk("err_both_ack", dmmu_ack, 1);
        chk("err_both_data", dmmu_data, 0);
        chk("err_both_pulse", err, 1);
        dmmu_req = 0;
        tick();  // c13 HOLD
        bus_ack = 1; bus_dat = 32'h55;
        tick();  // c14 IDLE
        tick();  // c15
        bus_ack = 0;
        chk("late_ack_ignored", {bus_req, busy, immu_ack, dmmu_ack, err}, 0);
        chk("late_ack_data", dmmu_data, 0);
        immu_req = 1; immu_addr = 32'h500;
        tick();  // c1
        bus_err = 1;
        tick();  // c2
        bus_err = 0;
        chk("err_immu_ack", immu_ack, 1);
        chk("err_immu_data", immu_data, 0);
        chk("err_immu_pulse", err, 1);
        immu_req = 0;
        tick(2);

        // Asynchronous reset in the middle of a read.
        immu_req = 1; immu_addr = 32'h600;
        tick();
        chk("arst_pre_req", bus_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_bus_req", bus_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_acks", {immu_ack, dmmu_ack, err}, 0);
        chk("arst_nt", {z_bus_req, z_busy}, 0);
        immu_req = 0;
        tick(2);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
